eth_decap: RTL
==============

ETH_DECAP -- requirements
Module: eth_decap

Interface
REQ-001 Parameter ETHERTYPE, default 16'h88B5, the EtherType accepted as a TLP-carrying frame.
REQ-002 Parameter MAX_LEN, default 16'd1500, the largest legal payload length in bytes.
REQ-003 clk156  in  1  sole clock; all logic on its rising edge.
REQ-004 sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axis_rx_tvalid/tdata/tkeep/tlast/tuser  in  1/64/8/1/1  MAC RX stream; there is no tready; tuser=1 on the tlast beat means good FCS; byte 0 is in tdata[7:0].
REQ-006 wr_en  out  1  FIFO write strobe.
REQ-007 din  out  74  FIFO word {err[73], tlast[72], tkeep[71:64], tdata[63:0]}.
REQ-008 full, prog_full  in  1 each  FIFO full, and FIFO cannot hold one MAX_LEN frame.
REQ-009 stat_rx_frames, stat_drop_type, stat_drop_len, stat_drop_ovf  out  16 each  wrapping event counters.
REQ-010 ovf_sticky  out  1  set on any FIFO overflow; cleared only by reset.

Function
REQ-011 Frame layout: beat0 = bytes 0-7, beat1 = bytes 8-15, payload from beat2 onward.
- Bytes 12-13: EtherType, big-endian; {tdata[39:32], tdata[47:40]} of beat1.
- Bytes 14-15: payload length L, big-endian; {tdata[55:48], tdata[63:56]} of beat1.
REQ-012 FSM states: IDLE, HDR1, PAYLOAD, PAD, DROP; the FSM advances only on tvalid=1 beats; gaps are allowed anywhere.
REQ-013 IDLE: a valid beat with tlast=0 moves to HDR1; a valid beat with tlast=1 increments stat_drop_len and stays in IDLE.
REQ-014 HDR1 on a valid beat, checks in priority order:
- tlast=1 -> stat_drop_len++, go to IDLE.
- EtherType != ETHERTYPE -> stat_drop_type++, go to DROP.
- L==0 or L>MAX_LEN -> stat_drop_len++, go to DROP.
- prog_full=1 -> stat_drop_ovf++, go to DROP.
- Otherwise latch beats=(L+7)>>3 and lastkeep (8'hFF when L[2:0]==0, else 8'hFF>>(8-L[2:0])), then go to PAYLOAD.
REQ-015 PAYLOAD: every payload beat except the final one is written one cycle after acceptance.
- Written word: wr_en=1, tlast=0, err=0, tkeep=8'hFF, tdata as received.
REQ-016 Final payload beat (beat number beats): held in an internal register with tkeep=lastkeep and tlast=1.
- If that input beat also has tlast=1, it is written the next cycle with err=~tuser, and the FSM returns to IDLE.
- Otherwise the FSM goes to PAD.
REQ-017 PAD: discards pad beats; on the input tlast beat, the held word is written the next cycle with err=~tuser, then IDLE.
REQ-018 Short frame: input tlast before the final payload beat writes that beat with tlast=1, err=1, tkeep as received; stat_drop_len++; then IDLE.
REQ-019 DROP: discards beats until tlast, then IDLE; nothing is written.
REQ-020 stat_rx_frames increments on the cycle the tlast=1 FIFO word of an admitted frame is written, including when err=1.
REQ-021 Overflow: if full=1 on a cycle that needs a write, then:
- The word is not written.
- stat_drop_ovf++ (once per frame) and ovf_sticky<=1.
- The rest of the frame is discarded (DROP, or IDLE if this was the tlast beat).
REQ-022 At most one FIFO write per cycle.
- A held final word and a new frame's beat0 never conflict, because beat0 produces no write.
REQ-023 Counters wrap from 16'hFFFF to 0; simultaneous increments of different counters are independent.

Reset
REQ-024 sys_rst_n=0 immediately forces the following, regardless of any frame in flight:
- FSM to IDLE; held-word valid cleared.
- wr_en=0, din=0, all counters 0, ovf_sticky=0.
REQ-025 After sys_rst_n deasserts, the block resynchronises as follows:
- Input beats arriving mid-frame are treated as beat0/beat1 of a new frame.
- Such frames are filtered by REQ-014; no partial frame from before the reset is ever completed.

Verification
REQ-026 Frame with EtherType 88B5, L=20, 6 beats, good tuser:
- FIFO receives 3 words: FF/0, FF/0, keep 8'h0F/tlast=1/err=0.
- stat_rx_frames=1.
REQ-027 Frame with L=16, 8 beats (pad), tuser=0 on the last beat:
- FIFO receives 2 words; the 2nd has keep FF, tlast=1, err=1.
- The 2nd word is written the cycle after input tlast.
REQ-028 Frame with EtherType 0800 -> no writes, stat_drop_type=1; frame with L=1501 -> no writes, stat_drop_len=1.
REQ-029 Frame with L=40 but input tlast on payload beat 3:
- FIFO receives 3 words; the 3rd has tlast=1 and err=1.
- stat_drop_len=1.
REQ-030 Overflow cases:
- prog_full=1 during beat1 -> frame dropped, stat_drop_ovf=1.
- full=1 during payload beat 2 -> beat 2 not written, ovf_sticky=1, rest of frame discarded.
REQ-031 Assert sys_rst_n=0 during PAYLOAD of a frame:
- All outputs are 0 immediately.
- After release, the next complete valid frame decodes exactly as in REQ-026.

Source files
------------

// File: rtl/eth_decap_if.sv
// -----------------------------------------------------------------------------
// eth_decap_if
// Bundles the MAC RX stream and the FIFO write side used by eth_decap.
//   s_axis_rx_tvalid/tdata/tkeep/tlast/tuser : MAC RX beat (no backpressure)
//   wr_en / din                              : FIFO write strobe and 74-bit word
//   full / prog_full                         : FIFO status flags
// Modports:
//   master : stream source, FIFO model (drives stream and flags, sees writes)
//   slave  : the decapsulator
// -----------------------------------------------------------------------------
interface eth_decap_if;
  logic        s_axis_rx_tvalid;
  logic [63:0] s_axis_rx_tdata;
  logic [7:0]  s_axis_rx_tkeep;
  logic        s_axis_rx_tlast;
  logic        s_axis_rx_tuser;
  logic        wr_en;
  logic [73:0] din;
  logic        full;
  logic        prog_full;

  modport master (
    output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
           s_axis_rx_tlast, s_axis_rx_tuser, full, prog_full,
    input  wr_en, din
  );

  modport slave (
    input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
           s_axis_rx_tlast, s_axis_rx_tuser, full, prog_full,
    output wr_en, din
  );
endinterface

// File: rtl/eth_decap.sv
// -----------------------------------------------------------------------------
// eth_decap
// Strips the 16-byte Ethernet/length header from TLP-carrying frames and
// writes the payload into a FIFO as {err, tlast, tkeep, tdata} words.
// Ports:
//   clk156          : sole clock, rising edge
//   sys_rst_n       : asynchronous active-low reset
//   bus (slave)     : MAC RX stream in, FIFO write strobe/word out, FIFO flags in
//   stat_rx_frames  : admitted frames whose tlast word was written
//   stat_drop_type  : frames dropped for a foreign EtherType
//   stat_drop_len   : frames with an illegal/short length
//   stat_drop_ovf   : frames lost to FIFO prog_full/full
//   ovf_sticky      : set on any FIFO overflow, cleared only by reset
// -----------------------------------------------------------------------------
module eth_decap #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter logic [15:0] MAX_LEN   = 16'd1500
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  eth_decap_if.slave  bus,
  output logic [15:0] stat_rx_frames,
  output logic [15:0] stat_drop_type,
  output logic [15:0] stat_drop_len,
  output logic [15:0] stat_drop_ovf,
  output logic        ovf_sticky
);

  typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, PAD, DROP} state_t;

  state_t      state_q, state_d;
  logic [13:0] beats_q, beats_d;       // payload beats expected
  logic [13:0] cnt_q, cnt_d;           // payload beats accepted so far
  logic [7:0]  lastkeep_q, lastkeep_d;
  logic [72:0] hold_q, hold_d;         // held final word {tlast, tkeep, tdata}
  logic        hold_vld_q, hold_vld_d;
  logic        wr_en_q, wr_en_d;
  logic [73:0] din_q, din_d;
  logic [15:0] frames_q, type_q, len_q, ovf_q;
  logic        sticky_q, sticky_d;
  logic        inc_frames, inc_type, inc_len, inc_ovf;

  logic        wr_req;
  logic [73:0] wr_word;

  // Header fields of beat1 (big-endian on the wire)
  logic [15:0] etype, plen;
  logic [13:0] beats_calc;
  logic [7:0]  lastkeep_calc;

  assign etype      = {bus.s_axis_rx_tdata[39:32], bus.s_axis_rx_tdata[47:40]};
  assign plen       = {bus.s_axis_rx_tdata[55:48], bus.s_axis_rx_tdata[63:56]};
  assign beats_calc = {1'b0, plen[15:3]} + {13'd0, |plen[2:0]};
  assign lastkeep_calc = (plen[2:0] == 3'd0) ? 8'hFF
                       : (8'hFF >> (4'd8 - {1'b0, plen[2:0]}));

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    cnt_d      = cnt_q;
    lastkeep_d = lastkeep_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    wr_en_d    = 1'b0;
    din_d      = din_q;
    sticky_d   = sticky_q;
    inc_frames = 1'b0;
    inc_type   = 1'b0;
    inc_len    = 1'b0;
    inc_ovf    = 1'b0;
    wr_req     = 1'b0;
    wr_word    = '0;

    if (bus.s_axis_rx_tvalid) begin
      case (state_q)
        IDLE: begin
          if (bus.s_axis_rx_tlast) inc_len = 1'b1;
          else                     state_d = HDR1;
        end
        HDR1: begin
          if (bus.s_axis_rx_tlast) begin
            inc_len = 1'b1;
            state_d = IDLE;
          end else if (etype != ETHERTYPE) begin
            inc_type = 1'b1;
            state_d  = DROP;
          end else if (plen == 16'd0 || plen > MAX_LEN) begin
            inc_len = 1'b1;
            state_d = DROP;
          end else if (bus.prog_full) begin
            inc_ovf = 1'b1;
            state_d = DROP;
          end else begin
            beats_d    = beats_calc;
            lastkeep_d = lastkeep_calc;
            cnt_d      = '0;
            hold_vld_d = 1'b0;
            state_d    = PAYLOAD;
          end
        end
        PAYLOAD: begin
          cnt_d = cnt_q + 14'd1;
          if (cnt_q + 14'd1 == beats_q) begin
            if (bus.s_axis_rx_tlast) begin
              wr_req  = 1'b1;
              wr_word = {~bus.s_axis_rx_tuser, 1'b1, lastkeep_q, bus.s_axis_rx_tdata};
              state_d = IDLE;
            end else begin
              hold_d     = {1'b1, lastkeep_q, bus.s_axis_rx_tdata};
              hold_vld_d = 1'b1;
              state_d    = PAD;
            end
          end else if (bus.s_axis_rx_tlast) begin
            // Frame ended before its declared length: flush what arrived as errored
            wr_req  = 1'b1;
            wr_word = {1'b1, 1'b1, bus.s_axis_rx_tkeep, bus.s_axis_rx_tdata};
            inc_len = 1'b1;
            state_d = IDLE;
          end else begin
            wr_req  = 1'b1;
            wr_word = {1'b0, 1'b0, 8'hFF, bus.s_axis_rx_tdata};
          end
        end
        PAD: begin
          if (bus.s_axis_rx_tlast) begin
            wr_req     = hold_vld_q;
            wr_word    = {~bus.s_axis_rx_tuser, hold_q};
            hold_vld_d = 1'b0;
            state_d    = IDLE;
          end
        end
        DROP: begin
          if (bus.s_axis_rx_tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // full is judged on the cycle the beat needing the write is accepted, so a
    // rejected word never reaches wr_en. Overflow takes precedence over the
    // short-frame count so each lost frame is charged to one counter only.
    if (wr_req) begin
      if (bus.full) begin
        inc_ovf    = 1'b1;
        inc_len    = 1'b0;
        sticky_d   = 1'b1;
        hold_vld_d = 1'b0;
        state_d    = bus.s_axis_rx_tlast ? IDLE : DROP;
      end else begin
        wr_en_d    = 1'b1;
        din_d      = wr_word;
        inc_frames = wr_word[72];
      end
    end
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      beats_q    <= '0;
      cnt_q      <= '0;
      lastkeep_q <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
      frames_q   <= '0;
      type_q     <= '0;
      len_q      <= '0;
      ovf_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      cnt_q      <= cnt_d;
      lastkeep_q <= lastkeep_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
      sticky_q   <= sticky_d;
      if (inc_frames) frames_q <= frames_q + 16'd1;
      if (inc_type)   type_q   <= type_q + 16'd1;
      if (inc_len)    len_q    <= len_q + 16'd1;
      if (inc_ovf)    ovf_q    <= ovf_q + 16'd1;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.din        = din_q;
  assign stat_rx_frames = frames_q;
  assign stat_drop_type = type_q;
  assign stat_drop_len  = len_q;
  assign stat_drop_ovf  = ovf_q;
  assign ovf_sticky     = sticky_q;

endmodule
